mem_bus_router: RTL and testbench
=================================

Name: mem_bus_router

Overview:
- Parametrised successor to the fixed four-bank memory bus decoder.
- Routes single CPU accesses to NUM_BANKS memory/peripheral banks selected by upper address bits.
- Adds a registered request/complete handshake with per-bank fixed wait states, a bank ready input (slow SPI-backed banks), a timeout and bus-error reporting.
- Sits between the CPU core and the ROM, RAM, peripheral and block-RAM instances.

Parameters:
- ADDR_WIDTH, 16, CPU address width.
- DATA_WIDTH, 16, data width.
- NUM_BANKS, 4, number of banks (2..8).
- BANK_MSB, 14, top address bit of the bank-select field; field = address[BANK_MSB -: clog2(NUM_BANKS)].
- WAIT_STATES, 0, packed 4 bits per bank; bank b fixed wait = WAIT_STATES[4*b +: 4].
- TIMEOUT, 255, maximum cycles to wait for bank_ready once fixed waits are exhausted (1..65535).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- address  in  ADDR_WIDTH  CPU address.
- data_in  in  DATA_WIDTH  CPU write data.
- bus_enable  in  1  request strobe.
- write_enable  in  1  1=write, 0=read; sampled with bus_enable.
- data_out  out  DATA_WIDTH  registered read data.
- bus_busy  out  1  access in progress; requests ignored.
- bus_done  out  1  one-cycle completion pulse.
- bus_error  out  1  one-cycle pulse with bus_done on timeout or unmapped bank.
- bank_address  out  ADDR_WIDTH  latched address to all banks.
- bank_data_in  out  DATA_WIDTH  latched write data to all banks.
- bank_read_enable  out  NUM_BANKS  one-hot read strobe.
- bank_write_enable  out  NUM_BANKS  one-hot write strobe.
- bank_data_out  in  NUM_BANKS*DATA_WIDTH  per-bank read data, bank b at [b*DATA_WIDTH +: DATA_WIDTH].
- bank_ready  in  NUM_BANKS  per-bank ready; tie high for combinational/BRAM banks.

Behaviour:
- Reset (reset=0, async) returns the block to IDLE immediately, mid-access included. All strobes, bus_busy, bus_done, bus_error, data_out and counters go to 0. No partial completion pulse is issued.
- IDLE:
  - On bus_enable=1 at a clk edge, latch address, data_in, write_enable and bank index.
  - Load the wait counter from WAIT_STATES for that bank; clear the timeout counter.
  - bus_busy=1 from the next cycle.
  - Unmapped bank (index >= NUM_BANKS): go to DONE with bus_error, no strobe.
  - Otherwise go to WAIT.
- WAIT: the selected strobe (read or write) is asserted and held.
  - Wait counter nonzero: decrement.
  - Wait counter zero and bank_ready[bank]=1: capture bank_data_out slice into data_out on reads (writes leave data_out unchanged); go to DONE.
  - Wait counter zero and bank_ready=0: increment the timeout counter. When it reaches TIMEOUT, drop the strobe and go to DONE with bus_error. A read on timeout loads data_out with all ones.
- DONE: strobes low, bus_done=1 (plus bus_error if flagged) for exactly one cycle, bus_busy=0. Return to IDLE.
- Latency:
  - Zero-wait, ready-high bank: bus_done two cycles after the accepting edge (accept, WAIT, DONE).
  - Each wait state adds one cycle; each not-ready cycle adds one.
- bus_enable during WAIT/DONE is ignored, with no queueing. bus_enable in the cycle after DONE (IDLE) is accepted normally.
- Strobes are never asserted for more than one bank at a time. Address and data are stable for the whole strobe.
- data_out holds its last value between accesses.

Optional Feature:
- Macro: MEM_BUS_ROUTER_STATS_EN.
- When defined:
  - Ports stat_accesses (32-bit, increments on each bus_done) and stat_stalls (32-bit, increments on each WAIT cycle spent waiting for bank_ready) are added.
  - Both counters clear on reset and saturate at all ones.
- When undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_bus_pkg holds:
  - state enum (IDLE, WAIT, DONE);
  - BANK_ROM/RAM/PERIPH/BRAM index constants;
  - the all-ones error read value.
- One sub-module is natural: mem_bus_bank_decode, the combinational address-to-bank index, valid flag and one-hot select.
- The FSM, counters and muxing stay in mem_bus_router.

Test Plan:
- NUM_BANKS=4, all ready high, WAIT_STATES=0: read 0x0010 with bank0 data 0x1234 -> bank_read_enable=4'b0001 one cycle, bus_done and data_out=0x1234 two cycles after accept.
- WAIT_STATES for bank1=3: write 0x2005 with 0xBEEF -> bank_write_enable=4'b0010 held 4 cycles, bank_data_in=0xBEEF, bus_done at cycle 5, data_out unchanged.
- bank2 ready held low, TIMEOUT=8: read 0x4000 -> strobe drops after 8 not-ready cycles, bus_done+bus_error pulse, data_out=0xFFFF.
- NUM_BANKS=3: read 0x6000 -> no strobe, bus_done+bus_error one cycle after accept.
- reset pulled low mid-WAIT -> strobes, bus_busy, data_out zero immediately; no bus_done. Next request after release completes normally.
- Back-to-back requests with bus_enable held high -> second accepted in the cycle after bus_done, never during busy. With MEM_BUS_ROUTER_STATS_EN, stat_accesses=2.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus router: FSM states,
// conventional bank indices and the data returned by a timed-out read.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int BANK_ROM    = 0;
    localparam int BANK_RAM    = 1;
    localparam int BANK_PERIPH = 2;
    localparam int BANK_BRAM   = 3;

    // Wide enough for any supported DATA_WIDTH; users slice the low bits.
    localparam int MAX_DATA_WIDTH = 64;
    localparam logic [MAX_DATA_WIDTH-1:0] ERR_READ_DATA = '1;

endpackage

// File: rtl/mem_bus_bank_decode.sv
// Combinational bank-select decode: turns the bank field of the CPU address
// into a one-hot select and a flag saying the field names an existing bank.
module mem_bus_bank_decode #(
    parameter int NUM_BANKS = 4,
    parameter int IDX_W     = $clog2(NUM_BANKS)
) (
    input  logic [IDX_W-1:0]     bank_field,
    output logic                 bank_valid,
    output logic [NUM_BANKS-1:0] bank_onehot
);

    always_comb begin
        bank_onehot = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_onehot[b] = (bank_field == IDX_W'(b));
        end
        // A field value past the last bank leaves the one-hot empty.
        bank_valid = |bank_onehot;
    end

endmodule

// File: rtl/mem_bus_router.sv
// Routes single CPU accesses to NUM_BANKS banks with per-bank wait states,
// bank_ready stalls, timeout and bus-error reporting.
// Optional access/stall counters are built when MEM_BUS_ROUTER_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting for bus_enable; request latched on acceptance
// WAIT  | strobe held; wait states then bank_ready/timeout
// DONE  | one-cycle bus_done (and bus_error) pulse, strobes low
module mem_bus_router
    import mem_bus_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 16,
    parameter int          DATA_WIDTH  = 16,
    parameter int          NUM_BANKS   = 4,
    parameter int          BANK_MSB    = 14,
    parameter logic [31:0] WAIT_STATES = 32'h0,
    parameter int          TIMEOUT     = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ADDR_WIDTH-1:0]           address,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic                            bus_enable,
    input  logic                            write_enable,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            bus_busy,
    output logic                            bus_done,
    output logic                            bus_error,
    output logic [ADDR_WIDTH-1:0]           bank_address,
    output logic [DATA_WIDTH-1:0]           bank_data_in,
    output logic [NUM_BANKS-1:0]            bank_read_enable,
    output logic [NUM_BANKS-1:0]            bank_write_enable,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_data_out,
    input  logic [NUM_BANKS-1:0]            bank_ready
`ifdef MEM_BUS_ROUTER_STATS_EN
    ,
    output logic [31:0]                     stat_accesses,
    output logic [31:0]                     stat_stalls
`endif
);

    localparam int          IDX_W  = $clog2(NUM_BANKS);
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    we_q, we_d;
    logic [NUM_BANKS-1:0]    sel_q, sel_d;
    logic [3:0]              wait_q, wait_d;
    logic [15:0]             to_q, to_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;

    logic [IDX_W-1:0]        bank_field;
    logic                    dec_valid;
    logic [NUM_BANKS-1:0]    dec_onehot;
    logic [3:0]              wait_load;
    logic [DATA_WIDTH-1:0]   rd_sel;
    logic                    rdy_sel;
    logic [15:0]             to_inc;
    logic                    stall;

    assign bank_field = address[BANK_MSB -: IDX_W];

    mem_bus_bank_decode #(
        .NUM_BANKS (NUM_BANKS),
        .IDX_W     (IDX_W)
    ) u_decode (
        .bank_field  (bank_field),
        .bank_valid  (dec_valid),
        .bank_onehot (dec_onehot)
    );

    always_comb begin
        wait_load = '0;
        rd_sel    = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (dec_onehot[b]) wait_load = WAIT_STATES[4*b +: 4];
            if (sel_q[b])      rd_sel    = bank_data_out[b*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign rdy_sel = |(bank_ready & sel_q);
    assign to_inc  = to_q + 16'd1;
    assign stall   = (state_q == WAIT) && (wait_q == 4'd0) && !rdy_sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wait_d  = wait_q;
        to_d    = to_q;
        err_d   = err_q;
        dout_d  = dout_q;
        unique case (state_q)
            IDLE: begin
                if (bus_enable) begin
                    addr_d  = address;
                    wdata_d = data_in;
                    we_d    = write_enable;
                    sel_d   = dec_onehot;
                    wait_d  = wait_load;
                    to_d    = '0;
                    err_d   = !dec_valid;
                    state_d = dec_valid ? WAIT : DONE;
                end
            end
            WAIT: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else if (rdy_sel) begin
                    if (!we_q) dout_d = rd_sel;
                    state_d = DONE;
                end else begin
                    to_d = to_inc;
                    if (to_inc == TO_LIM) begin
                        err_d   = 1'b1;
                        if (!we_q) dout_d = ERR_READ_DATA[DATA_WIDTH-1:0];
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wait_q  <= '0;
            to_q    <= '0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wait_q  <= wait_d;
            to_q    <= to_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        bus_busy          = 1'b0;
        bus_done          = 1'b0;
        bus_error         = 1'b0;
        bank_read_enable  = '0;
        bank_write_enable = '0;
        unique case (state_q)
            WAIT: begin
                bus_busy = 1'b1;
                if (we_q) bank_write_enable = sel_q;
                else      bank_read_enable  = sel_q;
            end
            DONE: begin
                bus_done  = 1'b1;
                bus_error = err_q;
            end
            default: ;
        endcase
    end

    assign data_out     = dout_q;
    assign bank_address = addr_q;
    assign bank_data_in = wdata_q;

`ifdef MEM_BUS_ROUTER_STATS_EN
    logic [31:0] acc_q, stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q   <= '0;
            stall_q <= '0;
        end else begin
            if (bus_done && (acc_q != '1))  acc_q   <= acc_q + 32'd1;
            if (stall && (stall_q != '1))   stall_q <= stall_q + 32'd1;
        end
    end

    assign stat_accesses = acc_q;
    assign stat_stalls   = stall_q;
`else
    logic unused_stall;
    assign unused_stall = stall;
`endif

endmodule

// File: tb/tb_mem_bus_router.sv
// Directed scoreboard bench for mem_bus_router (3 banks, bank1 has 3 wait
// states, timeout 8). Stats checks are included when MEM_BUS_ROUTER_STATS_EN is set.
module tb_mem_bus_router;
    import mem_bus_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int NB = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [AW-1:0]   address = '0;
    logic [DW-1:0]   data_in = '0;
    logic            bus_enable = 1'b0;
    logic            write_enable = 1'b0;
    logic [DW-1:0]   data_out;
    logic            bus_busy, bus_done, bus_error;
    logic [AW-1:0]   bank_address;
    logic [DW-1:0]   bank_data_in;
    logic [NB-1:0]   bank_read_enable, bank_write_enable;
    logic [NB*DW-1:0] bank_data_out;
    logic [NB-1:0]   bank_ready = '1;
`ifdef MEM_BUS_ROUTER_STATS_EN
    logic [31:0]     stat_accesses, stat_stalls;
`endif

    assign bank_data_out = {16'h9999, 16'h5555, 16'h1234};

    always #5 clk = ~clk;

    mem_bus_router #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .NUM_BANKS   (NB),
        .BANK_MSB    (14),
        .WAIT_STATES (32'h0000_0030),
        .TIMEOUT     (8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .address           (address),
        .data_in           (data_in),
        .bus_enable        (bus_enable),
        .write_enable      (write_enable),
        .data_out          (data_out),
        .bus_busy          (bus_busy),
        .bus_done          (bus_done),
        .bus_error         (bus_error),
        .bank_address      (bank_address),
        .bank_data_in      (bank_data_in),
        .bank_read_enable  (bank_read_enable),
        .bank_write_enable (bank_write_enable),
        .bank_data_out     (bank_data_out),
        .bank_ready        (bank_ready)
`ifdef MEM_BUS_ROUTER_STATS_EN
        ,
        .stat_accesses     (stat_accesses),
        .stat_stalls       (stat_stalls)
`endif
    );

    typedef struct {
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   exp_acc = 0;
    int   exp_stall = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one access, follow it to bus_done (bounded), then score it.
    task automatic access(input string tag, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic we, input logic [15:0] exp_data, input logic exp_err,
                          input logic [2:0] exp_strobe, input int exp_lat);
        int         lat = 0;
        int         strobe_cyc = 0;
        int         busy_cyc = 0;
        logic [2:0] rd_seen = '0;
        logic [2:0] wr_seen = '0;
        logic       lines_ok = 1'b1;
        int         exp_cyc;
        exp_t       e;
        address      = addr;
        data_in      = wdata;
        write_enable = we;
        bus_enable   = 1'b1;
        sb.push_back('{exp_data, exp_err});
        tick();
        bus_enable = 1'b0;
        data_in    = ~wdata;
        for (int c = 1; c <= 64; c++) begin
            if ((bank_read_enable | bank_write_enable) != '0) begin
                strobe_cyc++;
                if (bank_address !== addr || (we && bank_data_in !== wdata)) lines_ok = 1'b0;
            end
            rd_seen |= bank_read_enable;
            wr_seen |= bank_write_enable;
            if (bus_busy) busy_cyc++;
            if (bus_done) begin
                lat = c;
                break;
            end
            tick();
        end
        exp_cyc = (exp_strobe == '0) ? 0 : exp_lat - 1;
        e = sb.pop_front();
        check($sformatf("%s latency", tag), lat, exp_lat);
        check($sformatf("%s data_out", tag), data_out, e.data);
        check($sformatf("%s bus_error", tag), bus_error, e.err);
        check($sformatf("%s strobe_cycles", tag), strobe_cyc, exp_cyc);
        check($sformatf("%s busy_cycles", tag), busy_cyc, exp_cyc);
        check($sformatf("%s read_strobe", tag), rd_seen, we ? 3'b000 : exp_strobe);
        check($sformatf("%s write_strobe", tag), wr_seen, we ? exp_strobe : 3'b000);
        check($sformatf("%s bank_lines", tag), lines_ok, 1'b1);
        tick();
        check($sformatf("%s done_pulse", tag), {bus_done, bus_error}, 2'b00);
        exp_acc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   d1;
        int   d2;
        int   nd;
        int   dn;
        exp_t e;

        #3 reset = 1'b0;
        tick();
        tick();
        check("reset data_out", data_out, 16'h0000);
        check("reset busy_done_err", {bus_busy, bus_done, bus_error}, 3'b000);
        check("reset strobes", {bank_read_enable, bank_write_enable}, 6'b0);
        reset = 1'b1;
        tick();

        access("rd_rom", 16'h0010, 16'h0000, 1'b0, 16'h1234, 1'b0, 3'b001, 2);
        access("wr_ram_wait3", 16'h2005, 16'hBEEF, 1'b1, 16'h1234, 1'b0, 3'b010, 5);
        bank_ready = 3'b011;
        access("rd_periph_timeout", 16'h4000, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 3'b100, 9);
        exp_stall += 8;
        bank_ready = 3'b111;
        access("rd_unmapped", 16'h6000, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 3'b000, 1);
        access("rd_ram_wait3", 16'h2002, 16'h0000, 1'b0, 16'h5555, 1'b0, 3'b010, 5);
`ifdef MEM_BUS_ROUTER_STATS_EN
        check("stat_accesses pre_reset", stat_accesses, exp_acc);
        check("stat_stalls pre_reset", stat_stalls, exp_stall);
`endif

        // Reset pulled low in the middle of a waited read.
        address      = 16'h2000;
        write_enable = 1'b0;
        bus_enable   = 1'b1;
        sb.push_back('{16'h5555, 1'b0});
        tick();
        bus_enable = 1'b0;
        tick();
        check("midwait strobe", bank_read_enable, 3'b010);
        reset = 1'b0;
        #1;
        check("midwait_reset strobes", {bank_read_enable, bank_write_enable}, 6'b0);
        check("midwait_reset busy", bus_busy, 1'b0);
        check("midwait_reset data_out", data_out, 16'h0000);
        sb.delete();
        exp_acc   = 0;
        exp_stall = 0;
        dn = 0;
        tick();
        if (bus_done) dn++;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus_done) dn++;
        end
        check("midwait_reset no_done", dn, 0);

        access("rd_after_reset", 16'h0000, 16'h0000, 1'b0, 16'h1234, 1'b0, 3'b001, 2);

        // Back-to-back with bus_enable held; address changes while busy.
        address      = 16'h0004;
        write_enable = 1'b0;
        bus_enable   = 1'b1;
        sb.push_back('{16'h1234, 1'b0});
        sb.push_back('{16'h5555, 1'b0});
        d1 = 0;
        d2 = 0;
        nd = 0;
        tick();
        for (int c = 1; c <= 40; c++) begin
            if (c == 1) address = 16'h2006;
            if (c == 3) check("b2b idle_gap", {bus_busy, bus_done}, 2'b00);
            if (bus_done) begin
                nd++;
                e = sb.pop_front();
                check($sformatf("b2b data_out_%0d", nd), data_out, e.data);
                check($sformatf("b2b bus_error_%0d", nd), bus_error, e.err);
                if (nd == 1) begin
                    d1 = c;
                end else begin
                    d2 = c;
                    break;
                end
            end
            tick();
        end
        bus_enable = 1'b0;
        check("b2b first_done_cycle", d1, 2);
        check("b2b second_done_cycle", d2, 8);
        exp_acc += 2;
        tick();
        check("b2b done_pulse", bus_done, 1'b0);
`ifdef MEM_BUS_ROUTER_STATS_EN
        check("stat_accesses final", stat_accesses, exp_acc);
        check("stat_stalls final", stat_stalls, exp_stall);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
